// File: rtl/clk_div_gen_pkg.sv
// clk_div_gen_pkg: shared constants, divisor clamp helper and per-channel
// state record for the clk_div_gen clock-enable / divided-clock generator.
// Optional feature macro used by this block: CLK_DIV_GEN_PHASE_EN.
package clk_div_gen_pkg;

    // Default parameter values for the top level.
    localparam int NCH_DEF   = 4;
    localparam int DIV_W_DEF = 8;
    localparam int CYC_W_DEF = 16;

    // Widest half-period field a channel can be built with. The state record
    // below is sized to this so one typedef serves every DIV_W <= DIV_W_MAX;
    // bits above DIV_W are only ever loaded with zero.
    localparam int DIV_W_MAX = 32;

    typedef logic [DIV_W_MAX-1:0] div_t;

    // Per-channel state: position within the current half period, the
    // half-period length latched at the last toggle, and the output level.
    typedef struct packed {
        div_t cnt;
        div_t half_q;
        logic level;
    } chan_state_t;

    // A zero half-period is treated as one so a channel never stalls.
    function automatic div_t div_clamp(input div_t d);
        return (d == '0) ? div_t'(1) : d;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divided-clock channel. Produces a 50% duty square wave
// of period 2*H (H = clamped half-period) plus registered one-cycle rise and
// fall strobes that change on the same edge as the level.
// A new half-period is only adopted at a toggle, so no runt halves occur.
// Valid/ready note: this block has no handshake; every output is a plain
// registered level or a single-cycle strobe qualified by nothing else.
module clk_div_chan
    import clk_div_gen_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_i,
    input  logic [DIV_W-1:0] phase_i,
    output logic             clk_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             rise_nxt_o,
    output chan_state_t      state_o
);

    chan_state_t      st_q;
    chan_state_t      st_d;
    logic             rise_q;
    logic             fall_q;
    logic             rise_d;
    logic             fall_d;
    div_t             h;
    div_t             ph;
    logic [DIV_W-1:0] cnt_lo_inc;

    // Next-state: hold/preload while disabled, count and toggle while enabled.
    always_comb begin
        st_d       = st_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        h          = div_clamp(div_t'(div_i));
        ph         = div_t'(phase_i);
        cnt_lo_inc = st_q.cnt[DIV_W-1:0] + DIV_W'(1);
        if (!en) begin
            // Preload the start phase, clamped so the first half is never
            // longer than H; with no phase offset this is simply zero.
            st_d.cnt    = (ph > (h - div_t'(1))) ? (h - div_t'(1)) : ph;
            st_d.half_q = h;
            if (st_q.level) begin
                st_d.level = 1'b0;
                fall_d     = 1'b1;
            end
        end else if (st_q.cnt == (st_q.half_q - div_t'(1))) begin
            st_d.level  = ~st_q.level;
            st_d.cnt    = '0;
            st_d.half_q = h;
            rise_d      = ~st_q.level;
            fall_d      = st_q.level;
        end else begin
            st_d.cnt = div_t'(cnt_lo_inc);
        end
    end

    // State and strobe registers; reset forces a low level with no strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q.cnt    <= '0;
            st_q.half_q <= div_t'(1);
            st_q.level  <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
        end else begin
            st_q   <= st_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign clk_o      = st_q.level;
    assign rise_o     = rise_q;
    assign fall_o     = fall_q;
    assign rise_nxt_o = rise_d;
    assign state_o    = st_q;

endmodule

// File: rtl/clk_div_gen.sv
// clk_div_gen: NCH-channel divided-clock / strobe generator with a cycle
// counter on channel 0 rises and a sticky terminal-count flag.
// Optional feature macro: CLK_DIV_GEN_PHASE_EN adds phase_i, a per-channel
// start offset applied while en is low.
// Valid/ready note: no handshake; done_o is a sticky level cleared only by
// reset, cyc_o is a plain registered count.
module clk_div_gen
    import clk_div_gen_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int DIV_W = DIV_W_DEF,
    parameter int CYC_W = CYC_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [NCH*DIV_W-1:0] div_i,
`ifdef CLK_DIV_GEN_PHASE_EN
    input  logic [NCH*DIV_W-1:0] phase_i,
`endif
    input  logic [CYC_W-1:0]     term_i,
    output logic [NCH-1:0]       clk_o,
    output logic [NCH-1:0]       rise_o,
    output logic [NCH-1:0]       fall_o,
    output logic [CYC_W-1:0]     cyc_o,
    output logic                 done_o
);

    logic [NCH*DIV_W-1:0] phase_w;
    logic [NCH-1:0]       rise_nxt;
    chan_state_t          chan_st [NCH];
    logic [CYC_W-1:0]     cyc_q;
    logic                 done_q;

`ifdef CLK_DIV_GEN_PHASE_EN
    assign phase_w = phase_i;
`else
    // Without the phase feature every channel starts phase-aligned.
    assign phase_w = '0;
`endif

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        clk_div_chan #(
            .DIV_W (DIV_W)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en),
            .div_i      (div_i[k*DIV_W +: DIV_W]),
            .phase_i    (phase_w[k*DIV_W +: DIV_W]),
            .clk_o      (clk_o[k]),
            .rise_o     (rise_o[k]),
            .fall_o     (fall_o[k]),
            .rise_nxt_o (rise_nxt[k]),
            .state_o    (chan_st[k])
        );
    end

    // Only channel 0 rises feed the counter; the remaining look-ahead bits
    // and the per-channel state records are kept for debug probing.
    logic unused_dbg;
    always_comb begin
        unused_dbg = ^rise_nxt;
        for (int k = 0; k < NCH; k++) begin
            unused_dbg = unused_dbg ^ (^chan_st[k]);
        end
    end

    // Cycle counter: on each channel 0 rise, latch done on the pre-increment
    // match with term_i, otherwise count up, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q  <= '0;
            done_q <= 1'b0;
        end else if (rise_nxt[0] && !done_q) begin
            if (cyc_q == term_i) begin
                done_q <= 1'b1;
            end else if (cyc_q != '1) begin
                cyc_q <= cyc_q + CYC_W'(1);
            end
        end
    end

    assign cyc_o  = cyc_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: directed scenarios for clk_div_gen. Expected strobe events
// (channel, kind, edge index) are queued when stimulus is issued; a negedge
// monitor pops and compares every strobe the DUT presents.
module tb_clk_div_gen;

    localparam int NCH   = 4;
    localparam int DIV_W = 8;
    localparam int CYC_W = 16;
    localparam int W     = 32;
    localparam int NEVER = 100000;

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 en    = 1'b0;
    logic [NCH*DIV_W-1:0] div_i = '0;
`ifdef CLK_DIV_GEN_PHASE_EN
    logic [NCH*DIV_W-1:0] phase_i = '0;
`endif
    logic [CYC_W-1:0]     term_i = '0;
    logic [NCH-1:0]       clk_o;
    logic [NCH-1:0]       rise_o;
    logic [NCH-1:0]       fall_o;
    logic [CYC_W-1:0]     cyc_o;
    logic                 done_o;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    // Scoreboard entry: [31:30] channel, [29] 1=fall/0=rise, [28:0] edge.
    logic [W-1:0] exp_q[$];

    // Hand-set toggle schedule per channel: first toggle edge (relative to
    // the enable point), spacing for the first sc_na toggles, then sc_hb.
    int sc_f  [NCH];
    int sc_ha [NCH];
    int sc_na [NCH];
    int sc_hb [NCH];

    logic [NCH-1:0] prev_lvl = '0;

    clk_div_gen #(
        .NCH   (NCH),
        .DIV_W (DIV_W),
        .CYC_W (CYC_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .div_i   (div_i),
`ifdef CLK_DIV_GEN_PHASE_EN
        .phase_i (phase_i),
`endif
        .term_i  (term_i),
        .clk_o   (clk_o),
        .rise_o  (rise_o),
        .fall_o  (fall_o),
        .cyc_o   (cyc_o),
        .done_o  (done_o)
    );

    // Clock and edge index
    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mk_ev(input int ch, input int kind, input int e);
        return {ch[1:0], kind[0], e[28:0]};
    endfunction

    task automatic set_sched(input int h0, input int h1, input int h2, input int h3);
        sc_ha = '{h0, h1, h2, h3};
        sc_f  = '{h0, h1, h2, h3};
        sc_hb = '{h0, h1, h2, h3};
        sc_na = '{NEVER, NEVER, NEVER, NEVER};
    endtask

    // Queue the strobes for edges e0+1 .. e0+n from the schedule tables.
    task automatic push_sched(input int e0, input int n);
        int nxt [NCH];
        int cnt_t [NCH];
        for (int k = 0; k < NCH; k++) begin
            nxt[k]   = sc_f[k];
            cnt_t[k] = 0;
        end
        for (int t = 1; t <= n; t++) begin
            for (int k = 0; k < NCH; k++) begin
                if (t == nxt[k]) begin
                    exp_q.push_back(mk_ev(k, cnt_t[k] % 2, e0 + t));
                    cnt_t[k]++;
                    nxt[k] += (cnt_t[k] < sc_na[k]) ? sc_ha[k] : sc_hb[k];
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Cycle counter checks for runs with term_i=10 and channel 0 H=1:
    // rise n lands on edge 2n-1, so the 11th rise is edge 21.
    task automatic cyc_checks(input int t);
        if (t == 1) check("cyc_after_first_rise", cyc_o, 1);
        if (t == 20) begin
            check("cyc_before_term", cyc_o, 10);
            check("done_before_term", done_o, 0);
        end
        if (t == 21) begin
            check("done_on_11th_rise", done_o, 1);
            check("cyc_at_done", cyc_o, 10);
        end
        if (t == 24) begin
            check("cyc_frozen", cyc_o, 10);
            check("done_sticky", done_o, 1);
        end
    endtask

    // Close a run: every queued strobe must have appeared, then reset is
    // asserted between edges and all outputs must clear at once.
    task automatic end_run();
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_clk_o", clk_o, 0);
        check("async_rst_rise_o", rise_o, 0);
        check("async_rst_fall_o", fall_o, 0);
        check("async_rst_cyc_o", cyc_o, 0);
        check("async_rst_done_o", done_o, 0);
        en = 1'b0;
        @(negedge clk);
        #3 rst_n = 1'b1;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_lvl = '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (rise_o[k] && fall_o[k]) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL strobe_both ch%0d: rise and fall together at edge %0d", k, edge_n);
                end else if (rise_o[k] || fall_o[k]) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_strobe ch%0d: got %s at edge %0d, expected none",
                                 k, rise_o[k] ? "rise" : "fall", edge_n);
                    end else begin
                        check("strobe_event", mk_ev(k, fall_o[k] ? 1 : 0, edge_n), exp_q.pop_front());
                    end
                    check("strobe_level", clk_o[k], rise_o[k]);
                end
                check("level_vs_strobe", clk_o[k], prev_lvl[k] ^ (rise_o[k] | fall_o[k]));
                prev_lvl[k] = clk_o[k];
            end
        end
    end

    // Driver
    initial begin
        int e0;
        int e1;
        term_i = 16'd10;
        div_i  = {8'd4, 8'd3, 8'd2, 8'd1};
        #2 rst_n = 1'b0;
        #1;
        check("reset_clk_o", clk_o, 0);
        check("reset_rise_o", rise_o, 0);
        check("reset_fall_o", fall_o, 0);
        check("reset_cyc_o", cyc_o, 0);
        check("reset_done_o", done_o, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #3 rst_n = 1'b1;

        // Run A: H = 1,2,3,4 on channels 0..3, counter to term 10.
        set_sched(1, 2, 3, 4);
        step();
        e0 = edge_n;
        push_sched(e0, 24);
        en = 1'b1;
        for (int t = 1; t <= 24; t++) begin
            step();
            cyc_checks(t);
        end
        end_run();

        // Run B: zero divisor on channel 0 behaves as H=1; ends with clk_o[0]
        // high so the asynchronous reset has a live level to clear.
        div_i = {8'd4, 8'd3, 8'd2, 8'd0};
        set_sched(1, 2, 3, 4);
        step();
        e0 = edge_n;
        push_sched(e0, 21);
        en = 1'b1;
        for (int t = 1; t <= 21; t++) begin
            step();
            cyc_checks(t);
        end
        check("clk0_high_before_rst", clk_o[0], 1);
        end_run();

        // Run C: channel 1 divisor 2 -> 5 part-way through its second half.
        div_i = {8'd4, 8'd3, 8'd2, 8'd1};
        set_sched(1, 2, 3, 4);
        sc_na[1] = 2;
        sc_hb[1] = 5;
        step();
        e0 = edge_n;
        push_sched(e0, 24);
        en = 1'b1;
        for (int t = 1; t <= 24; t++) begin
            step();
            if (t == 3) div_i[15:8] = 8'd5;
            if (t == 8) check("ch1_held_long_half", clk_o[1], 0);
        end
        end_run();

        // Run D: drop en with clk_o[2] high, then re-enable.
        div_i = {8'd4, 8'd3, 8'd2, 8'd1};
        set_sched(1, 2, 3, 4);
        step();
        e0 = edge_n;
        push_sched(e0, 4);
        en = 1'b1;
        for (int t = 1; t <= 4; t++) step();
        check("ch2_high_before_drop", clk_o[2], 1);
        en = 1'b0;
        exp_q.push_back(mk_ev(2, 1, e0 + 5));
        exp_q.push_back(mk_ev(3, 1, e0 + 5));
        step();
        check("ch2_low_after_drop", clk_o[2], 0);
        check("ch2_fall_after_drop", fall_o[2], 1);
        step();
        step();
        e1 = edge_n;
        push_sched(e1, 12);
        en = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            step();
            if (t == 2) check("ch2_no_early_rise", clk_o[2], 0);
            if (t == 3) check("ch2_rise_after_reenable", rise_o[2], 1);
        end
        end_run();

`ifdef CLK_DIV_GEN_PHASE_EN
        // Run E: channel 0 H=4 with phase 3 rises one edge after enable.
        div_i   = {8'd4, 8'd3, 8'd2, 8'd4};
        phase_i = {8'd0, 8'd0, 8'd0, 8'd3};
        set_sched(4, 2, 3, 4);
        sc_f[0] = 1;
        step();
        e0 = edge_n;
        push_sched(e0, 12);
        en = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            step();
            if (t == 1) check("phase_first_rise", rise_o[0], 1);
        end
        end_run();
        phase_i = '0;
`endif

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
